acc_delta: RTL and testbench



---
 rtl/acc_delta_pkg.sv | 23 ++
 rtl/acc_delta_if.sv | 17 +
 rtl/acc_delta_skid.sv | 80 ++++++++
 rtl/acc_delta.sv | 90 +++++++++
 tb/tb_acc_delta.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/acc_delta_pkg.sv
// acc_delta_pkg: shared types for the acc_delta sum-differencing block.
//   ACC_DELTA_WIDTH : default token width
//   word_t          : one default-width sum/difference token
//   out_st_e        : single-register output stage state (base build)
//   skid_st_e       : 2-entry skid buffer occupancy (ACC_DELTA_SKID_EN build)
package acc_delta_pkg;

  localparam int ACC_DELTA_WIDTH = 16;

  typedef logic [ACC_DELTA_WIDTH-1:0] word_t;

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_FULL  = 1'b1
  } out_st_e;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_st_e;

endpackage

// File: rtl/acc_delta_if.sv
// acc_delta_if: WIDTH-wide valid/ready token channel.
//   data  : token payload, held stable by the producer until transfer
//   valid : producer has a token
//   ready : consumer accepts the token this cycle
// A transfer happens on a rising edge where valid && ready.
//   master : producer side (drives data/valid, sees ready)
//   slave  : consumer side (sees data/valid, drives ready)
interface acc_delta_if #(
  parameter int WIDTH = acc_delta_pkg::ACC_DELTA_WIDTH
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/acc_delta_skid.sv
// acc_delta_skid: generic WIDTH-wide 2-entry valid/ready skid buffer.
//   CLK    : clock, rising edge
//   _RESET : synchronous active-low reset, discards buffered tokens
//   s_ch   : upstream channel (slave); ready depends only on registered state
//   m_ch   : downstream channel (master); data comes straight from the head register
// Latency is one cycle (token lands in head), throughput is one token per
// cycle; the tail entry only fills when the downstream stalls.
module acc_delta_skid import acc_delta_pkg::*; #(
  parameter int WIDTH = ACC_DELTA_WIDTH
) (
  input  logic         CLK,
  input  logic         _RESET,
  acc_delta_if.slave   s_ch,
  acc_delta_if.master  m_ch
);

  skid_st_e         st, st_nxt;
  logic [WIDTH-1:0] head, tail;
  logic             s_rdy, m_vld, s_xfer, m_xfer;
  logic             ld_head_in, ld_head_tail, ld_tail;

  // Both decoded from the state register only: no ready path from m_ch.
  assign s_rdy  = (st != SK_TWO);
  assign m_vld  = (st != SK_EMPTY);
  assign s_xfer = s_ch.valid && s_rdy;
  assign m_xfer = m_vld && m_ch.ready;

  assign s_ch.ready = s_rdy;
  assign m_ch.valid = m_vld;
  assign m_ch.data  = head;

  always_ff @(posedge CLK) begin
    if (!_RESET) st <= SK_EMPTY;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt       = st;
    ld_head_in   = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail      = 1'b0;
    unique case (st)
      SK_EMPTY: begin
        if (s_xfer) begin
          ld_head_in = 1'b1;
          st_nxt     = SK_ONE;
        end
      end
      SK_ONE: begin
        if (s_xfer && m_xfer) begin
          ld_head_in = 1'b1;            // head drains and refills in one edge
        end else if (s_xfer) begin
          ld_tail = 1'b1;               // downstream stalled: park in tail
          st_nxt  = SK_TWO;
        end else if (m_xfer) begin
          st_nxt = SK_EMPTY;
        end
      end
      SK_TWO: begin
        if (m_xfer) begin
          ld_head_tail = 1'b1;
          st_nxt       = SK_ONE;
        end
      end
      default: st_nxt = SK_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (ld_head_in)        head <= s_ch.data;
      else if (ld_head_tail) head <= tail;
      if (ld_tail)           tail <= s_ch.data;
    end
  end

endmodule

// File: rtl/acc_delta.sv
// acc_delta: turns a stream of cumulative sums into per-token increments,
// out = in - previous in (mod 2^WIDTH). Inverse of the running-sum accumulator.
//   CLK    : clock, rising edge
//   _RESET : synchronous active-low reset (drops buffered token, prev=0)
//   clr    : next accepted sum is differenced against 0
//   in_ch  : cumulative sum tokens (slave)
//   out_ch : difference tokens (master), one cycle after acceptance
// Build option ACC_DELTA_SKID_EN: output goes through a 2-entry skid buffer so
// in_ready is registered; otherwise a single output register whose in_ready
// is combinational from out_ready.
module acc_delta import acc_delta_pkg::*; #(
  parameter int WIDTH = ACC_DELTA_WIDTH
) (
  input  logic         CLK,
  input  logic         _RESET,
  input  logic         clr,
  acc_delta_if.slave   in_ch,
  acc_delta_if.master  out_ch
);

  logic [WIDTH-1:0] prev, base, diff;
  logic             clr_pend, in_xfer;

  // A clr seen in the accepting cycle applies to that token directly.
  assign base    = (clr_pend || clr) ? '0 : prev;
  assign diff    = in_ch.data - base;
  assign in_xfer = in_ch.valid && in_ch.ready;

  always_ff @(posedge CLK) begin
    if (!_RESET) begin
      prev     <= '0;
      clr_pend <= 1'b0;
    end else if (in_xfer) begin
      prev     <= in_ch.data;
      clr_pend <= 1'b0;
    end else if (clr) begin
      clr_pend <= 1'b1;
    end
  end

`ifdef ACC_DELTA_SKID_EN

  acc_delta_if #(.WIDTH(WIDTH)) dif ();

  assign dif.data    = diff;
  assign dif.valid   = in_ch.valid;
  assign in_ch.ready = dif.ready;

  acc_delta_skid #(.WIDTH(WIDTH)) u_skid (
    .CLK    (CLK),
    ._RESET (_RESET),
    .s_ch   (dif),
    .m_ch   (out_ch)
  );

`else

  out_st_e          st, st_nxt;
  logic [WIDTH-1:0] data_q;
  logic             out_vld, out_xfer;

  assign out_vld  = (st == OS_FULL);
  assign out_xfer = out_vld && out_ch.ready;

  assign out_ch.valid = out_vld;
  assign out_ch.data  = data_q;
  assign in_ch.ready  = !out_vld || out_ch.ready;

  always_ff @(posedge CLK) begin
    if (!_RESET) st <= OS_EMPTY;
    else         st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      OS_EMPTY: if (in_xfer)              st_nxt = OS_FULL;
      OS_FULL:  if (out_xfer && !in_xfer) st_nxt = OS_EMPTY;
      default:                            st_nxt = OS_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!_RESET)      data_q <= '0;
    else if (in_xfer) data_q <= diff;
  end

`endif

endmodule

// File: tb/tb_acc_delta.sv
module tb_acc_delta;
  import acc_delta_pkg::*;

  localparam int N_RAND    = 10000;
  localparam int RAND_BUDG = 60000;

  logic CLK = 1'b0;
  logic _RESET = 1'b0;
  logic clr = 1'b0;

  acc_delta_if #(.WIDTH(ACC_DELTA_WIDTH)) in_if ();
  acc_delta_if #(.WIDTH(ACC_DELTA_WIDTH)) out_if ();

  acc_delta #(.WIDTH(ACC_DELTA_WIDTH)) dut (
    .CLK    (CLK),
    ._RESET (_RESET),
    .clr    (clr),
    .in_ch  (in_if),
    .out_ch (out_if)
  );

  always #5 CLK = ~CLK;

  int    total = 0;
  int    bad   = 0;
  word_t exp_q[$];
  word_t sum_q[$];
  word_t rsum;
  logic  xi, xo;
  word_t bp_in [4];
  int    idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: settle inputs, note which transfers the coming edge makes,
  // score any output transfer against the expected queue, then step past the edge.
  task automatic cyc();
    #1;
    xi = in_if.valid && in_if.ready;
    xo = out_if.valid && out_if.ready;
    if (xo === 1'b1) begin
      chk("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("out_seq", 32'(out_if.data), 32'(exp_q.pop_front()));
      rsum = rsum + out_if.data;
      if (sum_q.size() != 0) chk("acc_loopback", 32'(rsum), 32'(sum_q.pop_front()));
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic adv();
    if (xi) begin
      idx++;
      if (idx < 4) in_if.data = bp_in[idx];
      else         in_if.valid = 1'b0;
    end
  endtask

  initial begin
    word_t d, s;
    int    cycles, gen;

    rsum = '0;
    in_if.valid = 1'b0;
    in_if.data  = '0;
    out_if.ready = 1'b1;

    // reset state
    _RESET = 1'b0;
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_if.valid), 0);
    chk("rst_out_data",  32'(out_if.data), 0);
    chk("rst_in_ready",  32'(in_if.ready), 1);
    _RESET = 1'b1;

    // 5,12,12,30 -> 5,7,0,18, one cycle after acceptance
    in_if.valid = 1'b1;
    in_if.data = 16'd5;  exp_q.push_back(16'd5);  cyc();
    chk("seq_v0", 32'(out_if.valid), 1); chk("seq_d0", 32'(out_if.data), 5);
    in_if.data = 16'd12; exp_q.push_back(16'd7);  cyc();
    chk("seq_d1", 32'(out_if.data), 7);  chk("seq_rdy1", 32'(in_if.ready), 1);
    in_if.data = 16'd12; exp_q.push_back(16'd0);  cyc();
    chk("seq_d2", 32'(out_if.data), 0);
    in_if.data = 16'd30; exp_q.push_back(16'd18); cyc();
    chk("seq_d3", 32'(out_if.data), 18);
    in_if.valid = 1'b0; cyc();
    chk("seq_drain", 32'(out_if.valid), 0);

    // wrap: restart then FFF0, 0010 -> FFF0, 0020
    clr = 1'b1; cyc(); clr = 1'b0;
    in_if.valid = 1'b1;
    in_if.data = 16'hFFF0; exp_q.push_back(16'hFFF0); cyc();
    chk("wrap_d0", 32'(out_if.data), 32'h0000FFF0);
    in_if.data = 16'h0010; exp_q.push_back(16'h0020); cyc();
    chk("wrap_d1", 32'(out_if.data), 32'h00000020);
    in_if.valid = 1'b0; cyc();

    // clr alone between tokens, then clr coincident with acceptance
    clr = 1'b1; cyc(); clr = 1'b0;
    in_if.valid = 1'b1;
    in_if.data = 16'd100; exp_q.push_back(16'd100); cyc();
    chk("clr_d0", 32'(out_if.data), 100);
    in_if.data = 16'd150; exp_q.push_back(16'd50); cyc();
    chk("clr_d1", 32'(out_if.data), 50);
    in_if.valid = 1'b0; clr = 1'b1; cyc(); clr = 1'b0;
    chk("clr_idle_valid", 32'(out_if.valid), 0);
    in_if.valid = 1'b1;
    in_if.data = 16'd160; exp_q.push_back(16'd160); cyc();
    chk("clr_d2", 32'(out_if.data), 160);
    clr = 1'b1;
    in_if.data = 16'd160; exp_q.push_back(16'd160); cyc();
    clr = 1'b0;
    chk("clr_same_cycle", 32'(out_if.data), 160);
    in_if.data = 16'd175; exp_q.push_back(16'd15); cyc();
    chk("clr_after_same", 32'(out_if.data), 15);
    in_if.valid = 1'b0; cyc();

    // backpressure: prev=175, stream 200,210,225,240 with 5 stalled cycles
    bp_in = '{16'd200, 16'd210, 16'd225, 16'd240};
    exp_q.push_back(16'd25); exp_q.push_back(16'd10);
    exp_q.push_back(16'd15); exp_q.push_back(16'd15);
    out_if.ready = 1'b0;
    idx = 0; in_if.data = bp_in[0]; in_if.valid = 1'b1;
    cyc(); adv();
    chk("bp_valid", 32'(out_if.valid), 1);
    chk("bp_data",  32'(out_if.data), 25);
`ifdef ACC_DELTA_SKID_EN
    chk("bp_rdy_after1", 32'(in_if.ready), 1);
`else
    chk("bp_rdy_after1", 32'(in_if.ready), 0);
`endif
    for (int i = 0; i < 4; i++) begin
      cyc(); adv();
      chk("bp_hold_data",  32'(out_if.data), 25);
      chk("bp_hold_valid", 32'(out_if.valid), 1);
      chk("bp_rdy_low",    32'(in_if.ready), 0);
    end
    out_if.ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || in_if.valid); i++) begin
      cyc(); adv();
    end
    chk("bp_all_out", 32'(exp_q.size()), 0);
    chk("bp_all_in",  32'(idx), 4);

    // reset with a token buffered; prev=240 so 300 would give 60
    out_if.ready = 1'b0;
    in_if.valid = 1'b1; in_if.data = 16'd300; cyc();
    chk("mid_buffered", 32'(out_if.valid), 1);
    in_if.valid = 1'b0; _RESET = 1'b0; cyc();
    chk("mid_rst_valid", 32'(out_if.valid), 0);
    _RESET = 1'b1; out_if.ready = 1'b1;
    in_if.valid = 1'b1; in_if.data = 16'd9; exp_q.push_back(16'd9); cyc();
    chk("mid_after_rst", 32'(out_if.data), 9);
    in_if.valid = 1'b0; cyc();

    // random valid/ready: differences and acc loop-back
    clr = 1'b1; cyc(); clr = 1'b0;
    rsum = '0; s = '0; gen = 0; cycles = 0;
    while ((gen < N_RAND || exp_q.size() != 0 || in_if.valid) && cycles < RAND_BUDG) begin
      out_if.ready = ($urandom_range(3) != 0);
      cyc();
      cycles++;
      if (xi) in_if.valid = 1'b0;
      if (!in_if.valid && gen < N_RAND && $urandom_range(3) != 0) begin
        d = word_t'($urandom);
        s = s + d;
        in_if.data = s;
        exp_q.push_back(d);
        sum_q.push_back(s);
        in_if.valid = 1'b1;
        gen++;
      end
    end
    chk("rand_in_budget", 32'(cycles < RAND_BUDG), 1);
    chk("rand_all_out",   32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
